preamble_inserter: RTL and testbench

PREAMBLE_INSERTER -- requirements
Module: preamble_inserter

---
 rtl/preamble_inserter.sv | 219 +++++++++++++++++++++
 tb/tb_preamble_inserter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preamble_inserter.sv
// Preamble inserter: prefixes each AXI-stream packet with R repetitions of a
// programmable L-sample pattern followed by G all-zero guard samples, then
// forwards the packet itself with zero-latency pass-through.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// tvalid && tready are both high. A source holds tdata/tlast stable while
// tvalid is high and tready is low. In PREAMBLE/GUARD o_tvalid is held high and
// the input is back-pressured (i_tready=0). In PAYLOAD the input and output
// handshakes are the same event, because i_tready is o_tready and o_tvalid is
// i_tvalid.
module preamble_inserter #(
  parameter int BASE         = 0,
  parameter int WIDTH        = 32,
  parameter int MAX_PAT_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W = MAX_PAT_LOG2;
  localparam int DEPTH = 1 << MAX_PAT_LOG2;

  localparam logic [7:0] ADDR_CFG = 8'(BASE);
  localparam logic [7:0] ADDR_PTR = 8'(BASE + 1);
  localparam logic [7:0] ADDR_PAT = 8'(BASE + 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_GUARD    = 2'd2,
    S_PAYLOAD  = 2'd3
  } state_t;

  // Reset is asserted asynchronously but released only after two clock edges,
  // so the first state change can never land on the edge where reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Settings registers: the live copy the host writes at any time.
  logic [PTR_W-1:0] cfg_len_m1;
  logic [7:0]       cfg_rep;
  logic [7:0]       cfg_guard;
  logic [PTR_W-1:0] wr_ptr;

  // Working copy used by the running frame, so host writes only affect the
  // next frame.
  logic [PTR_W-1:0] w_len_m1;
  logic [7:0]       w_rep;
  logic [7:0]       w_guard;

  logic [WIDTH-1:0] pat_mem [DEPTH];

  state_t           state, state_n;
  logic [PTR_W-1:0] idx, idx_n;
  logic [7:0]       rep, rep_n;
  logic [7:0]       gcnt, gcnt_n;
  logic             frame_start;

  // Settings bus decode for configuration and pattern write pointer.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cfg_len_m1 <= PTR_W'(15);
      cfg_rep    <= 8'd10;
      cfg_guard  <= 8'd0;
      wr_ptr     <= '0;
    end else if (set_stb) begin
      case (set_addr)
        ADDR_CFG: begin
          cfg_len_m1 <= set_data[PTR_W-1:0];
          cfg_rep    <= set_data[15:8];
          cfg_guard  <= set_data[23:16];
        end
        ADDR_PTR: wr_ptr <= set_data[PTR_W-1:0];
        ADDR_PAT: wr_ptr <= wr_ptr + 1'b1;
        default:  ;
      endcase
    end
  end

  // Pattern memory: one sample written per strobe at the current pointer.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int k = 0; k < DEPTH; k++) pat_mem[k] <= '0;
    end else if (set_stb && (set_addr == ADDR_PAT)) begin
      pat_mem[wr_ptr] <= WIDTH'(set_data);
    end
  end

  // A frame starts on the IDLE exit; clear wins over starting.
  assign frame_start = (state == S_IDLE) && i_tvalid && !clear;

  // Latch the frame's L/R/G when the frame starts.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      w_len_m1 <= PTR_W'(15);
      w_rep    <= 8'd10;
      w_guard  <= 8'd0;
    end else if (frame_start) begin
      w_len_m1 <= cfg_len_m1;
      w_rep    <= cfg_rep;
      w_guard  <= cfg_guard;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= S_IDLE;
      idx   <= '0;
      rep   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rep   <= rep_n;
      gcnt  <= gcnt_n;
    end
  end

  // Next-state, counter updates and stream outputs.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rep_n    = rep;
    gcnt_n   = gcnt;
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = 1'b0;

    case (state)
      S_IDLE: begin
        // The waiting sample is not consumed here; it is taken in PAYLOAD.
        if (i_tvalid) begin
          idx_n  = '0;
          rep_n  = '0;
          gcnt_n = '0;
          if (cfg_rep != 8'd0)        state_n = S_PREAMBLE;
          else if (cfg_guard != 8'd0) state_n = S_GUARD;
          else                        state_n = S_PAYLOAD;
        end
      end

      S_PREAMBLE: begin
        o_tvalid = 1'b1;
        o_tdata  = pat_mem[idx];
        if (o_tready) begin
          if (idx == w_len_m1) begin
            idx_n = '0;
            if (rep == w_rep - 8'd1) begin
              rep_n   = '0;
              state_n = (w_guard != 8'd0) ? S_GUARD : S_PAYLOAD;
            end else begin
              rep_n = rep + 8'd1;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end

      S_GUARD: begin
        o_tvalid = 1'b1;
        if (o_tready) begin
          if (gcnt == w_guard - 8'd1) begin
            gcnt_n  = '0;
            state_n = S_PAYLOAD;
          end else begin
            gcnt_n = gcnt + 8'd1;
          end
        end
      end

      S_PAYLOAD: begin
        o_tdata  = i_tdata;
        o_tlast  = i_tlast;
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        if (i_tvalid && o_tready && i_tlast) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    // Soft clear abandons the frame on this edge; the output simply stops.
    if (clear) begin
      state_n = S_IDLE;
      idx_n   = '0;
      rep_n   = '0;
      gcnt_n  = '0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_preamble_inserter.sv
// Directed bench for preamble_inserter: a monitor pops an expected-word queue
// ({tlast, tdata}) on every output handshake; scenario code fills the queue
// from hand-built frames and checks control outputs at specific cycles.
module tb_preamble_inserter;

  localparam int BASE = 0;
  localparam int W    = 32;

  // ---------------- clock / reset ----------------
  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          clear    = 1'b0;
  logic          set_stb  = 1'b0;
  logic [7:0]    set_addr = 8'd0;
  logic [31:0]   set_data = 32'd0;
  logic [W-1:0]  i_tdata  = '0;
  logic          i_tlast  = 1'b0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready = 1'b1;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  preamble_inserter #(.BASE(BASE), .WIDTH(W), .MAX_PAT_LOG2(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp     = 0;
  int          n_err     = 0;
  int          out_cnt   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] pat_model[32];
  int          model_ptr = 0;
  bit          rnd_rdy   = 1'b0;
  bit          stall_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
    if (a == 8'(BASE + 1)) model_ptr = int'(d[4:0]);
    if (a == 8'(BASE + 2)) begin
      pat_model[model_ptr] = d;
      model_ptr = (model_ptr + 1) % 32;
    end
  endtask

  // Hold the current input sample until it is accepted (bounded).
  task automatic wait_accept(output int waited);
    bit acc;
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      acc = i_tvalid && i_tready;
      tick();
      if (acc) done = 1'b1;
      else begin
        waited++;
        if (waited > 3000) begin
          check("accept_timeout", 64'(waited), 64'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit gaps,
                          output int first_wait);
    int w;
    int g;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        i_tvalid = 1'b0;
        repeat (g) tick();
      end
      i_tvalid = 1'b1;
      i_tdata  = base + 32'(i);
      i_tlast  = (i == n - 1);
      wait_accept(w);
      if (i == 0) first_wait = w;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic push_frame(input int r, input int l, input int g, input int n,
                            input logic [31:0] base);
    for (int rr = 0; rr < r; rr++)
      for (int k = 0; k < l; k++) exp_q.push_back({1'b0, pat_model[k]});
    for (int k = 0; k < g; k++) exp_q.push_back(33'd0);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  // Output-ready driver: always ready, or a 50% coin flip per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every output handshake against the expected queue and
  // check that a stalled output holds still.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (stall_chk && prev_stall) begin
        check("stall_valid", 64'(o_tvalid), 64'd1);
        check("stall_data", 64'(o_tdata), 64'(prev_data));
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      if (o_tvalid && o_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_out", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 64'({o_tlast, o_tdata}), 64'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin
    int fw;
    int cnt0;
    for (int k = 0; k < 32; k++) pat_model[k] = 32'd0;

    // Reset: outputs quiet while held; a pending sample waits for sync release.
    i_tvalid = 1'b1;
    i_tdata  = 32'h0000_00D0;
    i_tlast  = 1'b1;
    repeat (3) tick();
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_o_tlast", 64'(o_tlast), 64'd0);
    check("rst_i_tready", 64'(i_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    push_frame(10, 16, 0, 1, 32'h0000_00D0);
    reset_n = 1'b1;
    tick();
    check("rst_sync_busy_edge1", 64'(busy), 64'd0);
    wait_accept(fw);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    wait_idle();

    // Defaults with a loaded 16-entry pattern: 160 pattern samples + 4 payload.
    for (int k = 0; k < 16; k++) set_write(8'(BASE + 2), 32'h0001_0001 * 32'(k + 1));
    cnt0 = out_cnt;
    push_frame(10, 16, 0, 4, 32'h0000_4000);
    send_pkt(4, 32'h0000_4000, 1'b0, fw);
    wait_idle();
    check("s1_out_count", 64'(out_cnt - cnt0), 64'd164);

    // L=4, R=2, G=3 with a 2-sample packet; busy drops right after d1.
    set_write(8'(BASE + 1), 32'd0);
    for (int k = 0; k < 4; k++) set_write(8'(BASE + 2), 32'h1111_0000 + 32'(k));
    set_write(8'(BASE + 0), 32'h0003_0203);
    push_frame(2, 4, 3, 2, 32'h0000_5000);
    send_pkt(2, 32'h0000_5000, 1'b0, fw);
    check("s2_busy_fall", 64'(busy), 64'd0);
    wait_idle();

    // R=0, G=0: pure pass-through with one idle cycle per packet start.
    set_write(8'(BASE + 0), 32'h0000_0003);
    push_frame(0, 4, 0, 3, 32'h0000_6000);
    push_frame(0, 4, 0, 2, 32'h0000_6100);
    send_pkt(3, 32'h0000_6000, 1'b0, fw);
    check("s3_idle_gap_a", 64'(fw), 64'd1);
    send_pkt(2, 32'h0000_6100, 1'b0, fw);
    check("s3_idle_gap_b", 64'(fw), 64'd1);
    wait_idle();

    // Random output stalls and input gaps: same sequence, stable when stalled.
    set_write(8'(BASE + 0), 32'h0003_0203);
    rnd_rdy   = 1'b1;
    stall_chk = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_frame(2, 4, 3, 3 + p, 32'h0000_7000 + 32'(p * 16));
      send_pkt(3 + p, 32'h0000_7000 + 32'(p * 16), 1'b1, fw);
    end
    wait_idle();
    stall_chk = 1'b0;
    rnd_rdy   = 1'b0;
    tick();
    tick();

    // Config write mid-frame: old R=2,G=3 kept, next frame uses R=3,G=0.
    push_frame(2, 4, 3, 2, 32'h0000_8000);
    push_frame(3, 4, 0, 2, 32'h0000_8100);
    fork
      send_pkt(2, 32'h0000_8000, 1'b0, fw);
      begin
        repeat (3) tick();
        set_write(8'(BASE + 0), 32'h0000_0303);
      end
    join
    send_pkt(2, 32'h0000_8100, 1'b0, fw);
    wait_idle();

    // Clear during preamble sample 5, then a full frame from pattern[0].
    set_write(8'(BASE + 0), 32'h0000_0203);
    for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, pat_model[k % 4]});
    push_frame(2, 4, 0, 2, 32'h0000_9000);
    fork
      send_pkt(2, 32'h0000_9000, 1'b0, fw);
      begin
        repeat (6) tick();
        check("s6_pre_clear_valid", 64'(o_tvalid), 64'd1);
        check("s6_pre_clear_data", 64'(o_tdata), 64'(pat_model[1]));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s6_clear_valid", 64'(o_tvalid), 64'd0);
        check("s6_clear_tlast", 64'(o_tlast), 64'd0);
        check("s6_clear_busy", 64'(busy), 64'd0);
      end
    join
    wait_idle();

    // Reset pulse mid-payload: quiet outputs while low, defaults afterwards.
    set_write(8'(BASE + 0), 32'h0000_0003);
    exp_q.push_back({1'b0, 32'h0000_A000});
    exp_q.push_back({1'b0, 32'h0000_A001});
    i_tvalid = 1'b1;
    i_tlast  = 1'b0;
    i_tdata  = 32'h0000_A000;
    tick();
    tick();
    i_tdata = 32'h0000_A001;
    tick();
    i_tdata = 32'h0000_A002;
    reset_n = 1'b0;
    #1;
    check("s7_rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("s7_rst_o_tlast", 64'(o_tlast), 64'd0);
    check("s7_rst_i_tready", 64'(i_tready), 64'd0);
    check("s7_rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("s7_rst_hold_o_tvalid", 64'(o_tvalid), 64'd0);
    i_tvalid = 1'b0;
    for (int k = 0; k < 32; k++) pat_model[k] = 32'd0;
    model_ptr = 0;
    reset_n   = 1'b1;
    repeat (3) tick();
    cnt0 = out_cnt;
    push_frame(10, 16, 0, 2, 32'h0000_B000);
    send_pkt(2, 32'h0000_B000, 1'b0, fw);
    wait_idle();
    check("s7_default_count", 64'(out_cnt - cnt0), 64'd162);

    check("queue_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
